// File: rtl/cpu_pkg.sv
// ---------------------------------------------------------------------------
// cpu_pkg
// Shared definitions for the 4-bit accumulator CPU:
//   - opcode values (instruction word bits [7:4])
//   - one-hot decode flag bit positions produced by instruction_decoder
//   - alu_sel encodings driven to the accumulator/ALU datapath
//   - control_unit FSM state encoding
// ---------------------------------------------------------------------------
package cpu_pkg;

  localparam logic [3:0] OP_LOAD      = 4'b0000;
  localparam logic [3:0] OP_BITAND    = 4'b0001;
  localparam logic [3:0] OP_ADD       = 4'b0100;
  localparam logic [3:0] OP_SUB       = 4'b0110;
  localparam logic [3:0] OP_JUMP      = 4'b1000;
  localparam logic [3:0] OP_JUMP_COND = 4'b1001;
  localparam logic [3:0] OP_INPUT     = 4'b1010;
  localparam logic [3:0] OP_OUTPUT    = 4'b1110;

  // Bit positions inside the eight-bit one-hot decode vector.
  localparam int F_LOAD   = 0;
  localparam int F_BITAND = 1;
  localparam int F_ADD    = 2;
  localparam int F_SUB    = 3;
  localparam int F_JUMP   = 4;
  localparam int F_JCOND  = 5;
  localparam int F_INPUT  = 6;
  localparam int F_OUTPUT = 7;
  localparam int N_FLAGS  = 8;

  localparam logic [1:0] ALU_PASS = 2'b00;
  localparam logic [1:0] ALU_ADD  = 2'b01;
  localparam logic [1:0] ALU_AND  = 2'b10;
  localparam logic [1:0] ALU_SUB  = 2'b11;

  typedef enum logic [1:0] {
    ST_FETCH  = 2'd0,
    ST_DECODE = 2'd1,
    ST_EXEC   = 2'd2,
    ST_HALT   = 2'd3
  } state_t;

endpackage

// File: rtl/instruction_decoder.sv
// ---------------------------------------------------------------------------
// instruction_decoder
// Maps a 4-bit opcode to a one-hot flag vector (bit positions F_* in
// cpu_pkg). An opcode outside the instruction set yields all zeros, which
// the sequencer treats as illegal.
// Ports:
//   i_opcode  in  4  opcode field of the instruction register
//   o_flags   out 8  one-hot decode flags, all zero when illegal
// ---------------------------------------------------------------------------
module instruction_decoder
  import cpu_pkg::*;
(
  input  logic [3:0]         i_opcode,
  output logic [N_FLAGS-1:0] o_flags
);

  always_comb begin
    o_flags = '0;
    case (i_opcode)
      OP_LOAD:      o_flags[F_LOAD]   = 1'b1;
      OP_BITAND:    o_flags[F_BITAND] = 1'b1;
      OP_ADD:       o_flags[F_ADD]    = 1'b1;
      OP_SUB:       o_flags[F_SUB]    = 1'b1;
      OP_JUMP:      o_flags[F_JUMP]   = 1'b1;
      OP_JUMP_COND: o_flags[F_JCOND]  = 1'b1;
      OP_INPUT:     o_flags[F_INPUT]  = 1'b1;
      OP_OUTPUT:    o_flags[F_OUTPUT] = 1'b1;
      default:      o_flags = '0;
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// ---------------------------------------------------------------------------
// control_unit
// Sequencer for the 4-bit accumulator CPU. Steps each instruction through
// FETCH -> DECODE -> EXEC, drives the program counter, accumulator write
// strobe and ALU select, runs the INPUT/OUTPUT handshakes and halts on an
// illegal opcode until reset.
//
// Handshakes: INPUT completes in the EXEC cycle where in_valid is 1; in that
// same cycle in_ack, acc_we and in_sel pulse together (combinational from
// state and in_valid). OUTPUT holds out_valid for the whole EXEC residency
// (Moore, state only) and completes on the first cycle out_ready is 1.
//
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   instr_in      program word at pc_out ([7:4] opcode, [3:0] operand)
//   zero_flag     accumulator == 0, sampled only in EXEC
//   in_valid      external input word available
//   out_ready     external sink accepts the accumulator value
//   pc_out        program counter
//   operand       IR[3:0]
//   alu_sel       00 pass, 01 add, 10 and, 11 sub
//   in_sel        accumulator source is the external input
//   acc_we        accumulator write strobe
//   in_ack        input consumed
//   out_valid     accumulator value offered to the sink
//   illegal       sticky halt indicator
//   o_state_dbg   current FSM state
// ---------------------------------------------------------------------------
module control_unit
  import cpu_pkg::*;
#(
  parameter int PC_BITS = 4,
  parameter int OP_BITS = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [2*OP_BITS-1:0] instr_in,
  input  logic                 zero_flag,
  input  logic                 in_valid,
  input  logic                 out_ready,
  output logic [PC_BITS-1:0]   pc_out,
  output logic [OP_BITS-1:0]   operand,
  output logic [1:0]           alu_sel,
  output logic                 in_sel,
  output logic                 acc_we,
  output logic                 in_ack,
  output logic                 out_valid,
  output logic                 illegal,
  output state_t               o_state_dbg
);

  state_t               r_state;
  state_t               w_next_state;
  logic [PC_BITS-1:0]   r_pc;
  logic [PC_BITS-1:0]   w_pc_next;
  logic [2*OP_BITS-1:0] r_ir;
  logic [N_FLAGS-1:0]   r_flags;
  logic [N_FLAGS-1:0]   w_dec_flags;
  logic [PC_BITS-1:0]   w_pc_inc;
  logic [PC_BITS-1:0]   w_pc_target;

  instruction_decoder u_dec (
    .i_opcode (r_ir[2*OP_BITS-1 -: 4]),
    .o_flags  (w_dec_flags)
  );

  // Natural wrap gives modulo 2^PC_BITS arithmetic.
  assign w_pc_inc    = r_pc + PC_BITS'(1);
  assign w_pc_target = PC_BITS'(r_ir[OP_BITS-1:0]);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_FETCH;
      r_pc    <= '0;
      r_ir    <= '0;
      r_flags <= '0;
    end else begin
      r_state <= w_next_state;
      r_pc    <= w_pc_next;
      if (r_state == ST_FETCH)  r_ir    <= instr_in;
      if (r_state == ST_DECODE) r_flags <= w_dec_flags;
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_pc_next    = r_pc;
    acc_we       = 1'b0;
    in_ack       = 1'b0;
    in_sel       = 1'b0;
    out_valid    = 1'b0;
    alu_sel      = ALU_PASS;
    case (r_state)
      ST_FETCH: w_next_state = ST_DECODE;
      ST_DECODE: begin
        w_next_state = (w_dec_flags == '0) ? ST_HALT : ST_EXEC;
      end
      ST_EXEC: begin
        if (r_flags[F_LOAD] || r_flags[F_BITAND] ||
            r_flags[F_ADD]  || r_flags[F_SUB]) begin
          acc_we       = 1'b1;
          if (r_flags[F_ADD])         alu_sel = ALU_ADD;
          else if (r_flags[F_BITAND]) alu_sel = ALU_AND;
          else if (r_flags[F_SUB])    alu_sel = ALU_SUB;
          else                        alu_sel = ALU_PASS;
          w_pc_next    = w_pc_inc;
          w_next_state = ST_FETCH;
        end else if (r_flags[F_JUMP]) begin
          w_pc_next    = w_pc_target;
          w_next_state = ST_FETCH;
        end else if (r_flags[F_JCOND]) begin
          w_pc_next    = zero_flag ? w_pc_target : w_pc_inc;
          w_next_state = ST_FETCH;
        end else if (r_flags[F_INPUT]) begin
          // Gated by rst so a word offered on the reset edge is not consumed.
          if (in_valid && !rst) begin
            in_sel       = 1'b1;
            acc_we       = 1'b1;
            in_ack       = 1'b1;
            w_pc_next    = w_pc_inc;
            w_next_state = ST_FETCH;
          end
        end else if (r_flags[F_OUTPUT]) begin
          out_valid = 1'b1;
          if (out_ready) begin
            w_pc_next    = w_pc_inc;
            w_next_state = ST_FETCH;
          end
        end else begin
          w_next_state = ST_HALT;
        end
      end
      ST_HALT: w_next_state = ST_HALT;
      default: w_next_state = ST_FETCH;
    endcase
  end

  assign pc_out      = r_pc;
  assign operand     = r_ir[OP_BITS-1:0];
  assign illegal     = (r_state == ST_HALT);
  assign o_state_dbg = r_state;

endmodule

// File: tb/tb_control_unit.sv
module tb_control_unit;
  import cpu_pkg::*;

  // ---------------- clock / reset / DUT ----------------
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] instr_in;
  logic       zero_flag = 1'b0;
  logic       in_valid  = 1'b0;
  logic       out_ready = 1'b0;
  logic [3:0] pc_out;
  logic [3:0] operand;
  logic [1:0] alu_sel;
  logic       in_sel, acc_we, in_ack, out_valid, illegal;
  state_t     state_dbg;

  logic [7:0] prog [16];
  assign instr_in = prog[pc_out];

  always #5 clk = ~clk;

  control_unit #(.PC_BITS(4), .OP_BITS(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .instr_in   (instr_in),
    .zero_flag  (zero_flag),
    .in_valid   (in_valid),
    .out_ready  (out_ready),
    .pc_out     (pc_out),
    .operand    (operand),
    .alu_sel    (alu_sel),
    .in_sel     (in_sel),
    .acc_we     (acc_we),
    .in_ack     (in_ack),
    .out_valid  (out_valid),
    .illegal    (illegal),
    .o_state_dbg(state_dbg)
  );

  // ---------------- scoreboard ----------------
  // Expected write record: {alu_sel, operand, in_sel, in_ack}
  logic [7:0] exp_q[$];
  int n_checks = 0;
  int n_err    = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every accumulator write is matched against the queue.
  always @(negedge clk) begin
    if (acc_we === 1'b1) begin
      logic [7:0] e;
      logic [7:0] a;
      n_checks++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL acc_we_unexpected: got write alu_sel=%0h operand=%0h expected no write", alu_sel, operand);
      end else begin
        e = exp_q.pop_front();
        a = {alu_sel, operand, in_sel, in_ack};
        // ALU select is irrelevant when the source is the external input.
        if (e[1]) begin
          a[7:6] = e[7:6];
        end
        if (a !== e) begin
          n_err++;
          $display("FAIL acc_write: got %0h expected %0h", a, e);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    check("rst_pc", pc_out, 4'h0);
    check("rst_state", state_dbg, ST_FETCH);
    check("rst_illegal", illegal, 1'b0);
    check("rst_strobes", {acc_we, in_ack, in_sel, out_valid}, 4'b0000);
    rst = 1'b0;
  endtask

  function automatic logic [7:0] wrec(input logic [1:0] sel, input logic [3:0] opd,
                                      input logic isel, input logic iack);
    return {sel, opd, isel, iack};
  endfunction

  logic [3:0] ill_ops [8];

  // ---------------- stimulus ----------------
  initial begin
    ill_ops = '{4'h2, 4'h3, 4'h5, 4'h7, 4'hB, 4'hC, 4'hD, 4'hF};
    for (int i = 0; i < 16; i++) prog[i] = 8'h80;
    prog[0]  = 8'h05;  // LOAD 5
    prog[1]  = 8'h9C;  // JUMP_COND C
    prog[12] = 8'h9C;  // JUMP_COND C
    prog[13] = 8'hA0;  // INPUT
    prog[14] = 8'hE0;  // OUTPUT

    do_reset();

    // LOAD 5: write in cycle 3, pc 1 in cycle 4
    check("load_c1_state", state_dbg, ST_FETCH);
    exp_q.push_back(wrec(ALU_PASS, 4'h5, 1'b0, 1'b0));
    tick();
    check("load_c2_we", acc_we, 1'b0);
    tick();
    check("load_c3_we", acc_we, 1'b1);
    tick();
    check("load_c4_pc", pc_out, 4'h1);

    // JUMP_COND taken
    zero_flag = 1'b1;
    tick(); tick();
    check("jc_taken_we", acc_we, 1'b0);
    tick();
    check("jc_taken_pc", pc_out, 4'hC);
    // JUMP_COND not taken
    zero_flag = 1'b0;
    tick(); tick();
    check("jc_not_we", acc_we, 1'b0);
    tick();
    check("jc_not_pc", pc_out, 4'hD);

    // INPUT with 4 wait cycles
    tick(); tick();
    for (int w = 0; w < 4; w++) begin
      check("in_wait_state", state_dbg, ST_EXEC);
      check("in_wait_strobes", {acc_we, in_ack, in_sel}, 3'b000);
      tick();
    end
    exp_q.push_back(wrec(2'b00, 4'h0, 1'b1, 1'b1));
    in_valid = 1'b1;
    #1;
    check("in_hs_strobes", {acc_we, in_ack, in_sel}, 3'b111);
    tick();
    in_valid = 1'b0;
    check("in_done_pc", pc_out, 4'hE);
    check("in_done_state", state_dbg, ST_FETCH);

    // OUTPUT stalled, then reset
    out_ready = 1'b0;
    tick();
    check("out_decode_valid", out_valid, 1'b0);
    tick();
    check("out_exec1_valid", out_valid, 1'b1);
    tick();
    check("out_exec2_valid", out_valid, 1'b1);
    check("out_exec2_pc", pc_out, 4'hE);
    rst = 1'b1;
    tick();
    check("out_rst_valid", out_valid, 1'b0);
    check("out_rst_pc", pc_out, 4'h0);
    check("out_rst_state", state_dbg, ST_FETCH);
    rst = 1'b0;

    // INPUT pending when reset arrives with in_valid
    prog[0] = 8'hA0;
    do_reset();
    tick(); tick();
    check("inrst_wait_ack", in_ack, 1'b0);
    rst = 1'b1;
    in_valid = 1'b1;
    #1;
    check("inrst_ack", {in_ack, acc_we}, 2'b00);
    tick();
    check("inrst_pc", pc_out, 4'h0);
    check("inrst_state", state_dbg, ST_FETCH);
    rst = 1'b0;
    in_valid = 1'b0;

    // Illegal opcodes, one per reset
    for (int k = 0; k < 8; k++) begin
      for (int i = 0; i < 16; i++) prog[i] = 8'h80;
      prog[0] = 8'h85;                // JUMP 5
      prog[5] = {ill_ops[k], 4'h3};
      do_reset();
      tick(); tick(); tick();
      check("ill_pc_before", pc_out, 4'h5);
      tick();
      check("ill_decode_flag", illegal, 1'b0);
      tick();
      check("ill_flag", illegal, 1'b1);
      check("ill_state", state_dbg, ST_HALT);
      in_valid  = 1'b1;
      out_ready = 1'b1;
      zero_flag = 1'b1;
      for (int c = 0; c < 10; c++) begin
        tick();
        check("ill_hold", {pc_out, illegal, acc_we, in_ack, in_sel, out_valid}, {4'h5, 5'b10000});
      end
      in_valid  = 1'b0;
      out_ready = 1'b0;
      zero_flag = 1'b0;
    end

    // PC wrap: JUMP F, ADD 1 at F, then BITAND, SUB, OUTPUT at 0..2
    for (int i = 0; i < 16; i++) prog[i] = 8'h80;
    prog[0]  = 8'h8F;
    prog[15] = 8'h41;
    do_reset();
    tick(); tick(); tick();
    check("wrap_jump_pc", pc_out, 4'hF);
    prog[0] = 8'h17;  // BITAND 7
    prog[1] = 8'h62;  // SUB 2
    prog[2] = 8'hE0;  // OUTPUT
    exp_q.push_back(wrec(ALU_ADD, 4'h1, 1'b0, 1'b0));
    tick(); tick();
    check("wrap_add_we", acc_we, 1'b1);
    tick();
    check("wrap_pc", pc_out, 4'h0);
    exp_q.push_back(wrec(ALU_AND, 4'h7, 1'b0, 1'b0));
    tick(); tick();
    check("and_we", acc_we, 1'b1);
    tick();
    check("and_pc", pc_out, 4'h1);
    exp_q.push_back(wrec(ALU_SUB, 4'h2, 1'b0, 1'b0));
    tick(); tick();
    check("sub_we", acc_we, 1'b1);
    tick();
    check("sub_pc", pc_out, 4'h2);
    tick(); tick();
    check("out_ok_valid", out_valid, 1'b1);
    out_ready = 1'b1;
    #1;
    check("out_ok_valid_ready", out_valid, 1'b1);
    tick();
    out_ready = 1'b0;
    check("out_ok_pc", pc_out, 4'h3);
    check("out_ok_valid_drop", out_valid, 1'b0);

    tick();
    check("queue_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
